// File: rtl/alu_multiciclo.sv
// ---------------------------------------------------------------------------
// alu_multiciclo
//
// Registered ALU with a start/busy/done handshake. Logic, shift and compare
// operations finish one clock after the start edge. MULT, DIV and MOD use an
// iterative unit that produces one bit per clock.
//
// Build option: ALU_MULDIV_EN
//   defined   - the shift-add multiplier and restoring divider are built.
//   undefined - MULT/DIV/MOD are reported as illegal opcodes. No
//               multiply/divide logic is generated.
//
// Parameters:
//   WIDTH    operand/result width (>= 8)
//   SHAMT_W  shift-amount width. Shifts use shamt mod WIDTH.
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   launch an operation (accepted only while busy = 0)
//   OPcode     in   5-bit operation select
//   op1, op2   in   operands A and B, captured when start is accepted
//   shamt      in   shift amount, captured when start is accepted
//   result     out  result, held until the next done
//   result_hi  out  upper product word for MULT, 0 for all other ops
//   zero       out  1 when result == 0
//   busy       out  high from the accepted start through the done cycle
//   done       out  one-cycle pulse, result valid
//   div_zero   out  DIV/MOD with op2 == 0
//   illegal    out  unsupported opcode
// ---------------------------------------------------------------------------
module alu_multiciclo #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [4:0]         OPcode,
    input  logic [WIDTH-1:0]   op1,
    input  logic [WIDTH-1:0]   op2,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic               zero,
    output logic               busy,
    output logic               done,
    output logic               div_zero,
    output logic               illegal
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_NOT  = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_XOR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_NE   = 5'b01000;
    localparam logic [4:0] OP_LT   = 5'b01001;
    localparam logic [4:0] OP_GT   = 5'b01010;
    localparam logic [4:0] OP_EQ   = 5'b01011;
    localparam logic [4:0] OP_GE   = 5'b01100;
    localparam logic [4:0] OP_LE   = 5'b01101;
    localparam logic [4:0] OP_MOD  = 5'b01110;
    localparam logic [4:0] OP_MULT = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIN
    } state_t;

    state_t             r_state;

    // The result of the current operation waits in these registers until
    // the FIN transition. This keeps the visible outputs stable while busy.
    logic [WIDTH-1:0]   r_pend_lo;
    logic [WIDTH-1:0]   r_pend_hi;
    logic               r_pend_ill;
    logic               r_pend_dz;

    logic [SHAMT_W-1:0] w_shamt_mod;
    logic [WIDTH-1:0]   w_single;
    logic               w_illegal;

    assign w_shamt_mod = SHAMT_W'(32'(shamt) % WIDTH);

`ifdef ALU_MULDIV_EN
    assign w_illegal = (OPcode > OP_DIV);
`else
    // Without the iterative unit, the three multi-cycle opcodes are illegal.
    assign w_illegal = (OPcode == OP_MOD) || (OPcode == OP_MULT) || (OPcode >= OP_DIV);
`endif

    // Single-cycle result, computed straight from the inputs at capture.
    // All comparisons are unsigned.
    always_comb begin
        w_single = '0;
        case (OPcode)
            OP_ADD:  w_single = op1 + op2;
            OP_SUB:  w_single = op1 - op2;
            OP_NOT:  w_single = ~op1;
            OP_AND:  w_single = op1 & op2;
            OP_OR:   w_single = op1 | op2;
            OP_XOR:  w_single = op1 ^ op2;
            OP_SHL:  w_single = op1 << w_shamt_mod;
            OP_SHR:  w_single = op1 >> w_shamt_mod;
            OP_NE:   w_single = WIDTH'(op1 != op2);
            OP_LT:   w_single = WIDTH'(op1 <  op2);
            OP_GT:   w_single = WIDTH'(op1 >  op2);
            OP_EQ:   w_single = WIDTH'(op1 == op2);
            OP_GE:   w_single = WIDTH'(op1 >= op2);
            OP_LE:   w_single = WIDTH'(op1 <= op2);
            default: w_single = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam int                CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvsr;
    logic               r_is_mod;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod_next;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ok;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;

    // Shift-add step. The low half of r_prod starts as the multiplier. Each
    // step adds the multiplicand into the high half when the current LSB is
    // set, then shifts the whole register right. The add's carry lands in the
    // top bit.
    assign w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_next = {w_mul_sum, r_prod[WIDTH-1:1]};

    // Restoring division step. Shift the next dividend bit into the partial
    // remainder, then try to subtract the divisor. A borrow, seen in the extra
    // top bit, means the subtraction is discarded.
    assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_dvsr};
    assign w_div_ok    = ~w_div_diff[WIDTH];
    assign w_rem_next  = w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_quo_next  = {r_quo[WIDTH-2:0], w_div_ok};
`endif

    // Control FSM and all registered outputs. After FIN, the FSM returns to
    // IDLE with busy and done still high for one cycle. That cycle is the
    // done pulse. start is only accepted once busy has dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            result     <= '0;
            result_hi  <= '0;
            zero       <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
            illegal    <= 1'b0;
            r_pend_lo  <= '0;
            r_pend_hi  <= '0;
            r_pend_ill <= 1'b0;
            r_pend_dz  <= 1'b0;
`ifdef ALU_MULDIV_EN
            r_count    <= '0;
            r_prod     <= '0;
            r_mcand    <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvsr     <= '0;
            r_is_mod   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (done) begin
                        done <= 1'b0;
                        busy <= 1'b0;
                    end else if (start) begin
                        busy       <= 1'b1;
                        div_zero   <= 1'b0;
                        illegal    <= 1'b0;
                        r_pend_hi  <= '0;
                        r_pend_ill <= 1'b0;
                        r_pend_dz  <= 1'b0;
                        if (w_illegal) begin
                            r_pend_lo  <= '0;
                            r_pend_ill <= 1'b1;
                            r_state    <= FIN;
                        end
`ifdef ALU_MULDIV_EN
                        else if (OPcode == OP_MULT) begin
                            r_prod  <= {{WIDTH{1'b0}}, op2};
                            r_mcand <= op1;
                            r_count <= '0;
                            r_state <= MUL;
                        end else if ((OPcode == OP_DIV) || (OPcode == OP_MOD)) begin
                            r_is_mod <= (OPcode == OP_MOD);
                            if (op2 == '0) begin
                                r_pend_lo <= (OPcode == OP_DIV) ? '1 : op1;
                                r_pend_dz <= 1'b1;
                                r_state   <= FIN;
                            end else begin
                                r_rem   <= '0;
                                r_quo   <= op1;
                                r_dvsr  <= op2;
                                r_count <= '0;
                                r_state <= DIV;
                            end
                        end
`endif
                        else begin
                            r_pend_lo <= w_single;
                            r_state   <= FIN;
                        end
                    end
                end
`ifdef ALU_MULDIV_EN
                MUL: begin
                    r_prod  <= w_prod_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST) begin
                        r_pend_lo <= w_prod_next[WIDTH-1:0];
                        r_pend_hi <= w_prod_next[2*WIDTH-1:WIDTH];
                        r_state   <= FIN;
                    end
                end
                DIV: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST) begin
                        r_pend_lo <= r_is_mod ? w_rem_next : w_quo_next;
                        r_state   <= FIN;
                    end
                end
`endif
                FIN: begin
                    result    <= r_pend_lo;
                    result_hi <= r_pend_hi;
                    zero      <= (r_pend_lo == '0);
                    div_zero  <= r_pend_dz;
                    illegal   <= r_pend_ill;
                    done      <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_alu_multiciclo
//
// Self-checking bench for alu_multiciclo (WIDTH = 32). It runs:
//   - a table of fixed single-cycle vectors,
//   - hand-written multi-cycle and handshake sequences,
//   - randomized operations compared against an arithmetic reference model.
// Both builds, with and without ALU_MULDIV_EN, are handled.
// ---------------------------------------------------------------------------
module tb_alu_multiciclo;

    localparam int WIDTH    = 32;
    localparam int SHAMT_W  = 5;
    localparam int LONG_LAT = WIDTH + 1;
    localparam int MAX_WAIT = 80;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_NOT  = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_XOR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_NE   = 5'b01000;
    localparam logic [4:0] OP_LT   = 5'b01001;
    localparam logic [4:0] OP_GT   = 5'b01010;
    localparam logic [4:0] OP_EQ   = 5'b01011;
    localparam logic [4:0] OP_GE   = 5'b01100;
    localparam logic [4:0] OP_LE   = 5'b01101;
    localparam logic [4:0] OP_MOD  = 5'b01110;
    localparam logic [4:0] OP_MULT = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;

    logic              clock;
    logic              reset_n;
    logic              start;
    logic [4:0]        OPcode;
    logic [WIDTH-1:0]  op1;
    logic [WIDTH-1:0]  op2;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]  result;
    logic [WIDTH-1:0]  result_hi;
    logic              zero;
    logic              busy;
    logic              done;
    logic              div_zero;
    logic              illegal;

    int nChecks = 0;
    int nPassed = 0;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] expRes;
        logic        expZero;
        logic        expIll;
    } vec_t;

    vec_t vecs[18];

    alu_multiciclo #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .OPcode    (OPcode),
        .op1       (op1),
        .op2       (op2),
        .shamt     (shamt),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .illegal   (illegal)
    );

    // 10 ns clock. Inputs change on the falling edge. Outputs are sampled
    // 1 ns after the rising edge.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            nPassed++;
    endtask

    // Present an operation for exactly one rising edge. Afterwards, scramble
    // the inputs so that any late use of them would show up as a wrong result.
    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh);
        @(negedge clock);
        OPcode = op;
        op1    = a;
        op2    = b;
        shamt  = sh;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start  = 1'b0;
        OPcode = 5'($urandom);
        op1    = $urandom;
        op2    = $urandom;
        shamt  = 5'($urandom);
    endtask

    // Count rising edges until done is seen, within a fixed bound. Also
    // record whether busy stayed high the whole time.
    task automatic waitDone(output int lat, output bit busyOk);
        lat    = 0;
        busyOk = (busy === 1'b1);
        while (done !== 1'b1 && lat < MAX_WAIT) begin
            @(posedge clock);
            #1;
            lat++;
            if (busy !== 1'b1) busyOk = 1'b0;
        end
    endtask

    task automatic runAndCheck(input string tag, input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] sh,
                               input logic [31:0] eRes, input logic [31:0] eHi, input logic eZero,
                               input logic eDz, input logic eIll, input int eLat);
        int lat;
        bit busyOk;
        applyStimulus(op, a, b, sh);
        waitDone(lat, busyOk);
        checkOutput({tag, " latency"},   64'(lat),       64'(eLat));
        checkOutput({tag, " result"},    64'(result),    64'(eRes));
        checkOutput({tag, " result_hi"}, 64'(result_hi), 64'(eHi));
        checkOutput({tag, " zero"},      64'(zero),      64'(eZero));
        checkOutput({tag, " div_zero"},  64'(div_zero),  64'(eDz));
        checkOutput({tag, " illegal"},   64'(illegal),   64'(eIll));
        checkOutput({tag, " busy held"}, 64'(busyOk),    64'd1);
        @(posedge clock);
        #1;
        checkOutput({tag, " done pulse"},   64'(done), 64'd0);
        checkOutput({tag, " busy release"}, 64'(busy), 64'd0);
    endtask

    // Reference model written directly from the opcode rules, using
    // plain 64-bit arithmetic.
    function automatic void refModel(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [4:0] sh, output logic [31:0] r, output logic [31:0] h,
                                     output logic dz, output logic il, output int lat);
        logic [63:0] p;
        r = '0; h = '0; dz = 1'b0; il = 1'b0; lat = 1; p = '0;
        case (op)
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
            OP_NOT: r = ~a;
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SHL: r = a << (int'(sh) % WIDTH);
            OP_SHR: r = a >> (int'(sh) % WIDTH);
            OP_NE:  r = (a != b) ? 32'd1 : 32'd0;
            OP_LT:  r = (a <  b) ? 32'd1 : 32'd0;
            OP_GT:  r = (a >  b) ? 32'd1 : 32'd0;
            OP_EQ:  r = (a == b) ? 32'd1 : 32'd0;
            OP_GE:  r = (a >= b) ? 32'd1 : 32'd0;
            OP_LE:  r = (a <= b) ? 32'd1 : 32'd0;
`ifdef ALU_MULDIV_EN
            OP_MULT: begin
                p = {32'b0, a} * {32'b0, b};
                r = p[31:0];
                h = p[63:32];
                lat = LONG_LAT;
            end
            OP_DIV: begin
                if (b == 0) begin r = '1; dz = 1'b1; end
                else begin r = a / b; lat = LONG_LAT; end
            end
            OP_MOD: begin
                if (b == 0) begin r = a; dz = 1'b1; end
                else begin r = a % b; lat = LONG_LAT; end
            end
`endif
            default: il = 1'b1;
        endcase
    endfunction

    // Fixed vectors. All are single-cycle or illegal, so latency is 1.
    task automatic tableTest();
        vecs[0]  = '{OP_ADD, 32'd5,          32'd7,          5'd0,  32'd12,         1'b0, 1'b0};
        vecs[1]  = '{OP_SUB, 32'd7,          32'd7,          5'd0,  32'd0,          1'b1, 1'b0};
        vecs[2]  = '{OP_SHL, 32'd1,          32'd0,          5'd31, 32'h8000_0000,  1'b0, 1'b0};
        vecs[3]  = '{OP_SHR, 32'h8000_0000,  32'd0,          5'd31, 32'd1,          1'b0, 1'b0};
        vecs[4]  = '{OP_NOT, 32'd0,          32'd9,          5'd0,  32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[5]  = '{OP_AND, 32'h0000_F0F0,  32'h0000_0FF0,  5'd0,  32'h0000_00F0,  1'b0, 1'b0};
        vecs[6]  = '{OP_OR,  32'h0000_F0F0,  32'h0000_0FF0,  5'd0,  32'h0000_FFF0,  1'b0, 1'b0};
        vecs[7]  = '{OP_XOR, 32'h0000_F0F0,  32'h0000_0FF0,  5'd0,  32'h0000_FF00,  1'b0, 1'b0};
        vecs[8]  = '{OP_NE,  32'd3,          32'd3,          5'd0,  32'd0,          1'b1, 1'b0};
        vecs[9]  = '{OP_LT,  32'd2,          32'hFFFF_FFFF,  5'd0,  32'd1,          1'b0, 1'b0};
        vecs[10] = '{OP_GT,  32'd2,          32'd3,          5'd0,  32'd0,          1'b1, 1'b0};
        vecs[11] = '{OP_EQ,  32'd9,          32'd9,          5'd0,  32'd1,          1'b0, 1'b0};
        vecs[12] = '{OP_GE,  32'd3,          32'd3,          5'd0,  32'd1,          1'b0, 1'b0};
        vecs[13] = '{OP_LE,  32'd4,          32'd3,          5'd0,  32'd0,          1'b1, 1'b0};
        vecs[14] = '{OP_ADD, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          1'b1, 1'b0};
        vecs[15] = '{OP_SUB, 32'd0,          32'd1,          5'd0,  32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[16] = '{5'b11111, 32'd6,        32'd6,          5'd0,  32'd0,          1'b1, 1'b1};
        vecs[17] = '{5'b10001, 32'd6,        32'd6,          5'd0,  32'd0,          1'b1, 1'b1};
        for (int i = 0; i < 18; i++) begin
            runAndCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh,
                        vecs[i].expRes, 32'd0, vecs[i].expZero, 1'b0, vecs[i].expIll, 1);
        end
    endtask

    task automatic handTests();
        int lat;
        bit busyOk;
        int nDone;

        // Flags clear on an accepted start, but result holds until done.
        runAndCheck("illegal 11111", 5'b11111, 32'd1, 32'd2, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1);
        @(negedge clock);
        OPcode = OP_ADD; op1 = 32'd5; op2 = 32'd7; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        checkOutput("flag clear at start", 64'(illegal), 64'd0);
        checkOutput("result held",         64'(result),  64'd0);
        checkOutput("busy after start",    64'(busy),    64'd1);
        @(posedge clock); #1;
        checkOutput("add done",   64'(done),   64'd1);
        checkOutput("add result", 64'(result), 64'd12);
        checkOutput("add zero",   64'(zero),   64'd0);
        @(posedge clock); #1;

        // start held high into the busy cycle must not launch a second op.
        @(negedge clock);
        OPcode = OP_SUB; op1 = 32'd50; op2 = 32'd8; start = 1'b1;
        @(posedge clock); #1;
        OPcode = OP_ADD; op1 = 32'd1; op2 = 32'd1;
        @(posedge clock); #1;
        start = 1'b0;
        checkOutput("held start done",   64'(done),   64'd1);
        checkOutput("held start result", 64'(result), 64'd42);
        nDone = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            if (done === 1'b1) nDone++;
        end
        checkOutput("held start extra done", 64'(nDone),  64'd0);
        checkOutput("held start kept",       64'(result), 64'd42);

`ifdef ALU_MULDIV_EN
        runAndCheck("mult max*2", OP_MULT, 32'hFFFF_FFFF, 32'd2, 5'd0,
                    32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0, 1'b0, LONG_LAT);
        runAndCheck("div 100/7", OP_DIV, 32'd100, 32'd7, 5'd0, 32'd14, 32'd0, 1'b0, 1'b0, 1'b0, LONG_LAT);
        runAndCheck("mod 100/7", OP_MOD, 32'd100, 32'd7, 5'd0, 32'd2,  32'd0, 1'b0, 1'b0, 1'b0, LONG_LAT);
        runAndCheck("div 9/0", OP_DIV, 32'd9, 32'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0, 1);
        runAndCheck("mod 9/0", OP_MOD, 32'd9, 32'd0, 5'd0, 32'd9, 32'd0, 1'b0, 1'b1, 1'b0, 1);
        runAndCheck("mod 6/3", OP_MOD, 32'd6, 32'd3, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, LONG_LAT);

        // An ADD pulsed in the middle of a DIV must be ignored.
        applyStimulus(OP_DIV, 32'd100, 32'd7, 5'd0);
        repeat (4) @(posedge clock);
        @(negedge clock);
        OPcode = OP_ADD; op1 = 32'd1; op2 = 32'd1; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        waitDone(lat, busyOk);
        checkOutput("div ignore latency", 64'(lat + 5), 64'(LONG_LAT));
        checkOutput("div ignore result",  64'(result),  64'd14);
        checkOutput("div ignore busy",    64'(busyOk),  64'd1);
        @(posedge clock); #1;
        checkOutput("div ignore single done", 64'(done), 64'd0);
        runAndCheck("add after done", OP_ADD, 32'd1, 32'd1, 5'd0, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0, 1);
`else
        runAndCheck("mult 3*4 illegal", OP_MULT, 32'd3, 32'd4, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1);
        runAndCheck("div 9/0 illegal",  OP_DIV,  32'd9, 32'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1);
        runAndCheck("mod 9/0 illegal",  OP_MOD,  32'd9, 32'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1);
        runAndCheck("add after done", OP_ADD, 32'd1, 32'd1, 5'd0, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0, 1);
`endif

        // Reset in the middle of an operation aborts it with no done.
        runAndCheck("pre-reset add", OP_ADD, 32'd5, 32'd7, 5'd0, 32'd12, 32'd0, 1'b0, 1'b0, 1'b0, 1);
        @(negedge clock);
`ifdef ALU_MULDIV_EN
        OPcode = OP_MULT;
`else
        OPcode = OP_ADD;
`endif
        op1 = 32'd3; op2 = 32'd4; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
`ifdef ALU_MULDIV_EN
        repeat (9) @(posedge clock);
`endif
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("abort busy",      64'(busy),      64'd0);
        checkOutput("abort result",    64'(result),    64'd0);
        checkOutput("abort zero",      64'(zero),      64'd1);
        checkOutput("abort done",      64'(done),      64'd0);
        checkOutput("abort result_hi", 64'(result_hi), 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        nDone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (done === 1'b1) nDone++;
        end
        checkOutput("abort no done", 64'(nDone), 64'd0);
        runAndCheck("post-reset add", OP_ADD, 32'd5, 32'd7, 5'd0, 32'd12, 32'd0, 1'b0, 1'b0, 1'b0, 1);
    endtask

    // Random operations, including illegal codes and zero divisors, checked
    // against refModel.
    task automatic randomPhase();
        logic [4:0]  op;
        logic [31:0] a, b, r, h;
        logic [4:0]  sh;
        logic        dz, il;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            op = 5'($urandom_range(0, 20));
            if (op > 5'd16) op = 5'($urandom_range(17, 31));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 300));
            sh = 5'($urandom);
            refModel(op, a, b, sh, r, h, dz, il, lat);
            runAndCheck($sformatf("rand%0d op%0d", i, op), op, a, b, sh, r, h, (r == 32'd0), dz, il, lat);
        end
    endtask

    initial begin
        reset_n = 1'b1;
        start   = 1'b0;
        OPcode  = '0;
        op1     = '0;
        op2     = '0;
        shamt   = '0;
        #1;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("reset result",    64'(result),    64'd0);
        checkOutput("reset result_hi", 64'(result_hi), 64'd0);
        checkOutput("reset zero",      64'(zero),      64'd1);
        checkOutput("reset busy",      64'(busy),      64'd0);
        checkOutput("reset done",      64'(done),      64'd0);
        checkOutput("reset div_zero",  64'(div_zero),  64'd0);
        checkOutput("reset illegal",   64'(illegal),   64'd0);
        reset_n = 1'b1;

        tableTest();
        handTests();
        randomPhase();

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule

// File: doc/alu_multiciclo.md
Name: alu_multiciclo

Overview:
Parametrised, registered successor of the datapath ALU. It keeps the 5-bit opcode map of the current ALU.
- Single-cycle ops (add..<=) finish in one clock.
- MULT/DIV/MOD run in a multi-cycle iterative unit with a start/busy/done handshake.
- Adds a correct zero flag, a high product word, and divide-by-zero and illegal-opcode flags.
- Sits between the register file and the writeback mux; the control FSM stalls on busy.

Parameters:
WIDTH, 32, operand/result width in bits (>=8)
SHAMT_W, 5, shift-amount width; shifts use shamt mod WIDTH

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  launch operation; accepted only when busy=0
OPcode  in  5  operation select (map below)
op1  in  WIDTH  operand A, captured at accepted start
op2  in  WIDTH  operand B, captured at accepted start
shamt  in  SHAMT_W  shift amount, captured at accepted start
result  out  WIDTH  registered result, held until next done
result_hi  out  WIDTH  upper product word for MULT, 0 otherwise
zero  out  1  1 when result == 0, updated with result
busy  out  1  high from accepted start until done cycle inclusive
done  out  1  one-cycle pulse, result valid
div_zero  out  1  set with done when DIV/MOD and op2 == 0
illegal  out  1  set with done when OPcode > 5'b10000

Behaviour:
- Opcode map, all unsigned:
  - 00000 add, 00001 sub, 00010 not op1, 00011 and, 00100 or, 00101 xor
  - 00110 shl, 00111 shr (logical)
  - 01000 !=, 01001 <, 01010 >, 01011 ==, 01100 >=, 01101 <= (compares give 1/0)
  - 01110 mod, 01111 mult, 10000 div
- Reset (async, reset_n=0):
  - state=IDLE.
  - result, result_hi, busy, done, div_zero, illegal = 0; zero = 1.
  - An in-flight op is aborted with no done.
- States: IDLE, MUL, DIV, FIN.
- IDLE with start=1:
  - Capture operands and go to FIN; busy=1 next cycle. This path applies to:
    - single-cycle ops, computed at capture;
    - illegal opcode: result=0, illegal=1;
    - DIV/MOD with op2==0: result={WIDTH{1'b1}} for DIV, op1 for MOD; div_zero=1.
  - MULT: go to MUL, counter=0.
  - DIV/MOD (op2!=0): go to DIV, counter=0.
- MUL: shift-add, one multiplier bit per cycle.
  - After WIDTH cycles, result = low WIDTH bits of the product, result_hi = high WIDTH bits.
  - Then go to FIN.
- DIV: restoring division, one quotient bit per cycle.
  - After WIDTH cycles, result = quotient (DIV) or remainder (MOD).
  - Then go to FIN.
- FIN: done=1 and busy=1 for one cycle, then IDLE; busy=0 the following cycle.
- Latency from the start edge to the edge where done is high:
  - single-cycle, illegal, divide-by-zero: 1 cycle;
  - MULT/DIV/MOD: WIDTH+1 cycles.
- start while busy=1: ignored. Operand changes during busy have no effect.
- Back-to-back: start may be asserted the cycle after done; it is accepted.
- result, result_hi, zero, flags change only at the FIN transition; flags are cleared at each accepted start.
- Arithmetic wraps modulo 2^WIDTH for add/sub; no overflow flag.

Optional Feature:
ALU_MULDIV_EN
- Defined: MUL/DIV states and the iterative unit are built, as above.
- Undefined: MULT/DIV/MOD are treated as illegal opcodes:
  - 1-cycle latency, result=0, result_hi=0, illegal=1;
  - div_zero is tied 0;
  - no multiplier/divider logic is synthesised.

Test Plan:
- Reset with reset_n=0 mid-MULT (cycle 10) -> done never pulses; busy=0, result=0, zero=1 immediately; next start works normally.
- ADD op1=5, op2=7 -> done 1 cycle after start, result=12, zero=0. SUB 7-7 -> result=0, zero=1. SHL op1=1, shamt=31 -> 0x80000000.
- MULT 0xFFFFFFFF*2 (WIDTH=32) -> done exactly 33 cycles after start, result=0xFFFFFFFE, result_hi=0x00000001, busy high throughout.
- DIV 100/7 -> result=14 at 33 cycles. MOD 100/7 -> result=2. DIV 9/0 -> 1 cycle, result=0xFFFFFFFF, div_zero=1. MOD 9/0 -> result=9, div_zero=1.
- Start DIV, then pulse start with ADD 1+1 during busy -> ADD ignored, only one done with the quotient; ADD issued the cycle after done -> result=2.
- OPcode=5'b11111 -> done after 1 cycle, result=0, illegal=1. With ALU_MULDIV_EN undefined, MULT 3*4 -> 1 cycle, result=0, illegal=1.
